encoder_input_decoder: RTL and testbench

ENCODER_INPUT_DECODER -- requirements
Module: encoder_input_decoder

---
 rtl/encoder_input_decoder.sv | 228 ++++++++++++++++++++++
 tb/tb_encoder_input_decoder.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/encoder_input_decoder.sv
// Rotary encoder front end: synchronizes the quadrature phases and push button,
// debounces the button, decodes detents and steers them to per-digit step pulses.
module encoder_input_decoder #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int TIMEOUT_CYCLES  = 1000000000
) (
  input  logic       i_Clk,
  input  logic       i_Reset_n,
  input  logic       i_Enc_A,
  input  logic       i_Enc_B,
  input  logic       i_Enc_Button,
  output logic       o_Encoder_Enable,
  output logic [2:0] o_Digit_Sel,
  output logic       o_Seconds_1st_Digit_Inc,
  output logic       o_Seconds_1st_Digit_Dec,
  output logic       o_Seconds_2nd_Digit_Inc,
  output logic       o_Seconds_2nd_Digit_Dec,
  output logic       o_Minutes_1st_Digit_Inc,
  output logic       o_Minutes_1st_Digit_Dec,
  output logic       o_Minutes_2nd_Digit_Inc,
  output logic       o_Minutes_2nd_Digit_Dec,
  output logic       o_Hours_1st_Digit_Inc,
  output logic       o_Hours_1st_Digit_Dec,
  output logic       o_Hours_2nd_Digit_Inc,
  output logic       o_Hours_2nd_Digit_Dec
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DB_W-1:0] DB_ONE  = DB_W'(1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_ONE  = TO_W'(1);
  localparam logic signed [2:0] ACC_MAX = 3'sd3;
  localparam logic signed [2:0] ACC_MIN = -3'sd3;

  typedef enum logic {IDLE = 1'b0, SET = 1'b1} state_t;

  logic [1:0]        r_A_Sync;
  logic [1:0]        r_B_Sync;
  logic [1:0]        r_Btn_Sync;
  logic [1:0]        r_Fill;
  logic              r_Btn_Db;
  logic              r_Btn_Db_Prev;
  logic [DB_W-1:0]   r_Db_Cnt;
  logic [1:0]        r_Prev_AB;
  logic              r_Primed;
  logic signed [2:0] r_Acc;
  logic              r_Det_Cw;
  logic              r_Det_Ccw;
  state_t            r_State;
  logic [2:0]        r_Digit_Sel;
  logic [TO_W-1:0]   r_To_Cnt;
  logic              r_Enable;
  logic [11:0]       r_Step;

  logic [1:0]        w_AB;
  logic              w_Press;
  logic              w_Step_Cw;
  logic              w_Step_Ccw;
  state_t            w_Next_State;
  logic [2:0]        w_Next_Digit;
  logic [TO_W-1:0]   w_Next_To;
  logic [11:0]       w_Next_Step;

  assign w_AB    = {r_A_Sync[1], r_B_Sync[1]};
  assign w_Press = r_Btn_Db & ~r_Btn_Db_Prev;

  // Two-flop synchronizers; r_Fill marks when the second stage holds a real sample.
  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      r_A_Sync   <= 2'b00;
      r_B_Sync   <= 2'b00;
      r_Btn_Sync <= 2'b00;
      r_Fill     <= 2'b00;
    end else begin
      r_A_Sync   <= {r_A_Sync[0], i_Enc_A};
      r_B_Sync   <= {r_B_Sync[0], i_Enc_B};
      r_Btn_Sync <= {r_Btn_Sync[0], i_Enc_Button};
      r_Fill     <= {r_Fill[0], 1'b1};
    end
  end

  // Button debounce and rising-edge history
  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      r_Btn_Db      <= 1'b0;
      r_Btn_Db_Prev <= 1'b0;
      r_Db_Cnt      <= '0;
    end else begin
      r_Btn_Db_Prev <= r_Btn_Db;
      if (r_Btn_Sync[1] != r_Btn_Db) begin
        if (r_Db_Cnt == DB_LAST) begin
          r_Btn_Db <= r_Btn_Sync[1];
          r_Db_Cnt <= '0;
        end else begin
          r_Db_Cnt <= r_Db_Cnt + DB_ONE;
        end
      end else begin
        r_Db_Cnt <= '0;
      end
    end
  end

  // Gray-code step classification; double-bit changes fall through as invalid
  always_comb begin
    w_Step_Cw  = 1'b0;
    w_Step_Ccw = 1'b0;
    case ({r_Prev_AB, w_AB})
      4'b0001, 4'b0111, 4'b1110, 4'b1000: w_Step_Cw  = 1'b1;
      4'b0010, 4'b1011, 4'b1101, 4'b0100: w_Step_Ccw = 1'b1;
      default: begin
        w_Step_Cw  = 1'b0;
        w_Step_Ccw = 1'b0;
      end
    endcase
  end

  // Quarter-step accumulator producing registered detent strobes
  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      r_Prev_AB <= 2'b00;
      r_Primed  <= 1'b0;
      r_Acc     <= 3'sd0;
      r_Det_Cw  <= 1'b0;
      r_Det_Ccw <= 1'b0;
    end else begin
      r_Det_Cw  <= 1'b0;
      r_Det_Ccw <= 1'b0;
      if (r_Fill[1]) begin
        r_Prev_AB <= w_AB;
        r_Primed  <= 1'b1;
        if (r_Primed && w_Step_Cw) begin
          if (r_Acc == ACC_MAX) begin
            r_Det_Cw <= 1'b1;
            r_Acc    <= 3'sd0;
          end else begin
            r_Acc <= r_Acc + 3'sd1;
          end
        end else if (r_Primed && w_Step_Ccw) begin
          if (r_Acc == ACC_MIN) begin
            r_Det_Ccw <= 1'b1;
            r_Acc     <= 3'sd0;
          end else begin
            r_Acc <= r_Acc - 3'sd1;
          end
        end
      end
    end
  end

  // Mode FSM: press beats detent and timeout in the same cycle
  always_comb begin
    w_Next_State = r_State;
    w_Next_Digit = r_Digit_Sel;
    w_Next_To    = r_To_Cnt;
    w_Next_Step  = 12'd0;
    case (r_State)
      IDLE: begin
        w_Next_To    = '0;
        w_Next_Digit = 3'd0;
        if (w_Press) begin
          w_Next_State = SET;
        end else begin
          w_Next_State = IDLE;
        end
      end
      SET: begin
        if (w_Press) begin
          w_Next_To = '0;
          if (r_Digit_Sel >= 3'd5) begin
            w_Next_State = IDLE;
            w_Next_Digit = 3'd0;
          end else begin
            w_Next_Digit = r_Digit_Sel + 3'd1;
          end
        end else if (r_Det_Cw || r_Det_Ccw) begin
          w_Next_To   = '0;
          w_Next_Step = 12'd1 << {r_Digit_Sel, r_Det_Ccw};
        end else if (r_To_Cnt == TO_LAST) begin
          w_Next_State = IDLE;
          w_Next_Digit = 3'd0;
          w_Next_To    = '0;
        end else begin
          w_Next_To = r_To_Cnt + TO_ONE;
        end
      end
      default: begin
        w_Next_State = IDLE;
        w_Next_Digit = 3'd0;
        w_Next_To    = '0;
      end
    endcase
  end

  // FSM state and registered outputs
  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      r_State     <= IDLE;
      r_Digit_Sel <= 3'd0;
      r_To_Cnt    <= '0;
      r_Enable    <= 1'b0;
      r_Step      <= 12'd0;
    end else begin
      r_State     <= w_Next_State;
      r_Digit_Sel <= w_Next_Digit;
      r_To_Cnt    <= w_Next_To;
      r_Enable    <= (w_Next_State == SET);
      r_Step      <= w_Next_Step;
    end
  end

  assign o_Encoder_Enable        = r_Enable;
  assign o_Digit_Sel             = r_Digit_Sel;
  assign o_Seconds_1st_Digit_Inc = r_Step[0];
  assign o_Seconds_1st_Digit_Dec = r_Step[1];
  assign o_Seconds_2nd_Digit_Inc = r_Step[2];
  assign o_Seconds_2nd_Digit_Dec = r_Step[3];
  assign o_Minutes_1st_Digit_Inc = r_Step[4];
  assign o_Minutes_1st_Digit_Dec = r_Step[5];
  assign o_Minutes_2nd_Digit_Inc = r_Step[6];
  assign o_Minutes_2nd_Digit_Dec = r_Step[7];
  assign o_Hours_1st_Digit_Inc   = r_Step[8];
  assign o_Hours_1st_Digit_Dec   = r_Step[9];
  assign o_Hours_2nd_Digit_Inc   = r_Step[10];
  assign o_Hours_2nd_Digit_Dec   = r_Step[11];

endmodule

// File: tb/tb_encoder_input_decoder.sv
// Bench for encoder_input_decoder: scenario tasks plus randomized moves, checked
// against an integer model of mode, digit and quarter-step accumulator.
module tb_encoder_input_decoder;

  logic clk = 1'b0;
  logic rst_n, enc_a, enc_b, btn;
  logic o_Encoder_Enable;
  logic [2:0] o_Digit_Sel;
  logic s1i, s1d, s2i, s2d, m1i, m1d, m2i, m2d, h1i, h1d, h2i, h2d;
  logic [11:0] steps;

  assign steps = {h2d, h2i, h1d, h1i, m2d, m2i, m1d, m1i, s2d, s2i, s1d, s1i};

  encoder_input_decoder #(.DEBOUNCE_CYCLES(4), .TIMEOUT_CYCLES(100)) dut (
    .i_Clk(clk), .i_Reset_n(rst_n), .i_Enc_A(enc_a), .i_Enc_B(enc_b),
    .i_Enc_Button(btn), .o_Encoder_Enable(o_Encoder_Enable), .o_Digit_Sel(o_Digit_Sel),
    .o_Seconds_1st_Digit_Inc(s1i), .o_Seconds_1st_Digit_Dec(s1d),
    .o_Seconds_2nd_Digit_Inc(s2i), .o_Seconds_2nd_Digit_Dec(s2d),
    .o_Minutes_1st_Digit_Inc(m1i), .o_Minutes_1st_Digit_Dec(m1d),
    .o_Minutes_2nd_Digit_Inc(m2i), .o_Minutes_2nd_Digit_Dec(m2d),
    .o_Hours_1st_Digit_Inc(h1i), .o_Hours_1st_Digit_Dec(h1d),
    .o_Hours_2nd_Digit_Inc(h2i), .o_Hours_2nd_Digit_Dec(h2d)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int m_in_set, m_digit, m_acc, m_pos;
  logic [1:0] gray [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // kind: 0=CW, 1=CCW, 2=invalid double-bit change, 3=no change
  task automatic enc_move(input int kind, input string tag);
    int exp_idx;
    logic [11:0] exp_v;
    exp_idx = -1;
    case (kind)
      0: begin
        m_pos = (m_pos + 1) % 4;
        if (m_acc == 3) begin m_acc = 0; if (m_in_set != 0) exp_idx = m_digit * 2; end
        else m_acc++;
      end
      1: begin
        m_pos = (m_pos + 3) % 4;
        if (m_acc == -3) begin m_acc = 0; if (m_in_set != 0) exp_idx = m_digit * 2 + 1; end
        else m_acc--;
      end
      2: m_pos = (m_pos + 2) % 4;
      default: ;
    endcase
    {enc_a, enc_b} = gray[m_pos];
    for (int k = 1; k <= 5; k++) begin
      tick(1);
      exp_v = (k == 4 && exp_idx >= 0) ? (12'd1 << exp_idx) : 12'd0;
      checks++;
      if (steps !== exp_v) begin
        failures++;
        $display("FAIL %s step_outputs cycle %0d: got %b, required %b", tag, k, steps, exp_v);
      end
    end
  endtask

  task automatic model_press();
    if (m_in_set == 0) begin m_in_set = 1; m_digit = 0; end
    else if (m_digit == 5) begin m_in_set = 0; m_digit = 0; end
    else m_digit++;
  endtask

  task automatic press_plain(input string tag);
    btn = 1'b1;
    tick(10);
    btn = 1'b0;
    tick(10);
    model_press();
    checks++;
    if (o_Encoder_Enable !== (m_in_set != 0) || o_Digit_Sel !== 3'(m_digit)) begin
      failures++;
      $display("FAIL %s press_mode: got en=%b sel=%0d, required en=%0d sel=%0d",
               tag, o_Encoder_Enable, o_Digit_Sel, m_in_set, m_digit);
    end
  endtask

  // Press whose effect lands exactly 7 edges after the button is driven; returns at that edge.
  task automatic press_timed(input string tag);
    btn = 1'b1;
    tick(6);
    checks++;
    if (o_Encoder_Enable !== (m_in_set != 0) || o_Digit_Sel !== 3'(m_digit)) begin
      failures++;
      $display("FAIL %s press_early: got en=%b sel=%0d, required en=%0d sel=%0d",
               tag, o_Encoder_Enable, o_Digit_Sel, m_in_set, m_digit);
    end
    tick(1);
    model_press();
    checks++;
    if (o_Encoder_Enable !== (m_in_set != 0) || o_Digit_Sel !== 3'(m_digit)) begin
      failures++;
      $display("FAIL %s press_edge: got en=%b sel=%0d, required en=%0d sel=%0d",
               tag, o_Encoder_Enable, o_Digit_Sel, m_in_set, m_digit);
    end
    btn = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; enc_a = 1'b1; enc_b = 1'b1; btn = 1'b0;
    m_pos = 2; m_acc = 0; m_in_set = 0; m_digit = 0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({o_Encoder_Enable, o_Digit_Sel, steps} !== 16'd0) begin
      failures++;
      $display("FAIL reset_async: got %h, required 0", {o_Encoder_Enable, o_Digit_Sel, steps});
    end
    tick(3);
    #3 rst_n = 1'b1;
    tick(5);
    checks++;
    if ({o_Encoder_Enable, o_Digit_Sel, steps} !== 16'd0) begin
      failures++;
      $display("FAIL reset_release: got %h, required 0", {o_Encoder_Enable, o_Digit_Sel, steps});
    end
  endtask

  task automatic test_idle_detent();
    for (int i = 0; i < 4; i++) enc_move(0, "idle_cw");
    checks++;
    if (o_Encoder_Enable !== 1'b0 || o_Digit_Sel !== 3'd0) begin
      failures++;
      $display("FAIL idle_mode: got en=%b sel=%0d, required en=0 sel=0", o_Encoder_Enable, o_Digit_Sel);
    end
  endtask

  task automatic test_press_bounce();
    for (int g = 0; g < 2; g++) begin
      btn = 1'b1; tick(2);
      btn = 1'b0; tick(2);
    end
    btn = 1'b1; tick(10);
    btn = 1'b0; tick(10);
    model_press();
    checks++;
    if (o_Encoder_Enable !== 1'b1 || o_Digit_Sel !== 3'd0) begin
      failures++;
      $display("FAIL bounce_press: got en=%b sel=%0d, required en=1 sel=0", o_Encoder_Enable, o_Digit_Sel);
    end
    for (int i = 0; i < 4; i++) enc_move(0, "sec1_inc");
  endtask

  task automatic test_ccw_digit2();
    press_plain("to_digit1");
    press_plain("to_digit2");
    for (int i = 0; i < 4; i++) enc_move(1, "min1_dec");
  endtask

  task automatic test_reversal_invalid();
    enc_move(2, "to_00");
    enc_move(0, "rev_a");
    enc_move(0, "rev_b");
    enc_move(1, "rev_c");
    enc_move(1, "rev_d");
    enc_move(2, "invalid");
    for (int i = 0; i < 4; i++) enc_move(0, "acc_zero_probe");
  endtask

  task automatic test_timeout();
    press_timed("to_digit3");
    tick(99);
    checks++;
    if (o_Encoder_Enable !== 1'b1 || o_Digit_Sel !== 3'd3) begin
      failures++;
      $display("FAIL timeout_early: got en=%b sel=%0d, required en=1 sel=3", o_Encoder_Enable, o_Digit_Sel);
    end
    tick(1);
    m_in_set = 0; m_digit = 0;
    checks++;
    if (o_Encoder_Enable !== 1'b0 || o_Digit_Sel !== 3'd0) begin
      failures++;
      $display("FAIL timeout_exit: got en=%b sel=%0d, required en=0 sel=0", o_Encoder_Enable, o_Digit_Sel);
    end
    tick(10);
    for (int i = 0; i < 3; i++) press_plain("reenter");
    press_timed("again_digit3");
    tick(93);
    press_timed("press_vs_timeout");
    tick(10);
  endtask

  task automatic test_reset_mid();
    press_plain("to_digit5");
    press_plain("wrap_idle");
    press_plain("enter_set");
    for (int i = 0; i < 3; i++) enc_move(0, "pre_reset");
    #2 rst_n = 1'b0;
    #1;
    m_in_set = 0; m_digit = 0; m_acc = 0;
    checks++;
    if ({o_Encoder_Enable, o_Digit_Sel, steps} !== 16'd0) begin
      failures++;
      $display("FAIL mid_reset: got %h, required 0", {o_Encoder_Enable, o_Digit_Sel, steps});
    end
    @(posedge clk);
    #3 rst_n = 1'b1;
    tick(4);
    enc_move(0, "post_reset");
    press_plain("enter_after_reset");
    for (int i = 0; i < 3; i++) enc_move(0, "acc_after_reset");
  endtask

  task automatic test_random();
    int n, kind;
    for (int r = 0; r < 8; r++) begin
      press_plain("rand_press");
      n = $urandom_range(1, 12);
      for (int j = 0; j < n; j++) begin
        kind = $urandom_range(0, 3);
        enc_move(kind, "rand_move");
      end
      checks++;
      if (o_Encoder_Enable !== (m_in_set != 0) || o_Digit_Sel !== 3'(m_digit)) begin
        failures++;
        $display("FAIL rand_mode: got en=%b sel=%0d, required en=%0d sel=%0d",
                 o_Encoder_Enable, o_Digit_Sel, m_in_set, m_digit);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_idle_detent();
    test_press_bounce();
    test_ccw_digit2();
    test_reversal_invalid();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
